// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, GF(2^8) helpers and key-expansion state type
package aes_pkg;

  localparam int AES_NR128 = 10;

  typedef enum logic [0:0] {KX_IDLE, KX_EMIT} kx_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - key load request and round-key handshake bundle
interface aes_key_expand_if;

  logic         start;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  // master: key loader / round datapath side; slave: the key expander
  modport master (
    output start, key_in, rk_ready,
    input  rk_valid, rk_out, rk_idx, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_valid, rk_out, rk_idx, busy, done
  );

endinterface

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one AES-128 key schedule step: round key n -> round key n+1
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rw, sw, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign rw = rot_word(w3);

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .a (rw[8*g +: 8]),
        .y (sw[8*g +: 8])
      );
    end
  endgenerate

  assign t  = sw ^ {rcon, 24'h0};
  // Each new word chains off the previous new word, so this is a 4-deep XOR ripple.
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Row r holds entries 16*r .. 16*r+15; element 0 sits at the MSB end.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative AES-128 key expansion emitting round keys 0..10 on a valid/ready handshake
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES_NR128
) (
  input  logic               clk,
  input  logic               rst,
  aes_key_expand_if.slave    kx
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  kx_state_t    state;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic [7:0]   rcon;
  logic         busy;
  logic         done;
  logic [127:0] next_key;

  aes_key_step u_step (
    .rk       (rk_out),
    .rcon     (rcon),
    .next_key (next_key)
  );

  // All outputs are registered, so rk_ready never reaches rk_valid/rk_out/rk_idx combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= KX_IDLE;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
      rcon     <= 8'h01;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        KX_IDLE: begin
          if (kx.start) begin
            state    <= KX_EMIT;
            rk_out   <= kx.key_in;
            rk_idx   <= '0;
            rcon     <= 8'h01;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        KX_EMIT: begin
          if (rk_valid && kx.rk_ready) begin
            if (rk_idx == LAST_IDX) begin
              state    <= KX_IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_out <= next_key;
              rk_idx <= rk_idx + 4'd1;
              rcon   <= xtime(rcon);
            end
          end
        end
      endcase
    end
  end

  assign kx.rk_valid = rk_valid;
  assign kx.rk_out   = rk_out;
  assign kx.rk_idx   = rk_idx;
  assign kx.busy     = busy;
  assign kx.done     = done;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - directed self-checking bench for aes_key_expand
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  aes_key_expand_if kx ();

  aes_key_expand #(.ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx)
  );

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;

  // FIPS-197 A.1 round keys for K1
  logic [127:0] t1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int hs, dn, cyc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] key);
    kx.start  = 1'b1;
    kx.key_in = key;
    step();
    kx.start  = 1'b0;
    kx.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Consume the K1 schedule; optionally pulses start with ALT while idx == poke.
  task automatic drain(input bit rnd, input int poke, output int nhs, output int ndn, output int ncyc);
    bit rdy;
    nhs = 0; ndn = 0; ncyc = 0;
    while (nhs < 11 && ncyc < 200) begin
      chk("valid", 128'(kx.rk_valid), 128'd1);
      chk("busy", 128'(kx.busy), 128'd1);
      chk("idx", 128'(kx.rk_idx), 128'(nhs));
      chk("key", kx.rk_out, t1[nhs]);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      kx.rk_ready = rdy;
      kx.start    = (nhs == poke);
      kx.key_in   = ALT;
      step();
      ncyc++;
      if (rdy) nhs++;
      if (kx.done) ndn++;
    end
    kx.start = 1'b0;
    chk("drain_handshakes", 128'(nhs), 128'd11);
  endtask

  initial begin
    kx.start    = 1'b0;
    kx.key_in   = '0;
    kx.rk_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_valid", 128'(kx.rk_valid), 128'd0);
    chk("rst_busy", 128'(kx.busy), 128'd0);
    chk("rst_done", 128'(kx.done), 128'd0);
    chk("rst_idx", 128'(kx.rk_idx), 128'd0);
    chk("rst_out", kx.rk_out, 128'd0);
    rst = 1'b0;
    step();

    // T1: FIPS-197 A.1, ready tied high, start->done = 12 cycles
    pulse_start(K1);
    drain(1'b0, -1, hs, dn, cyc);
    chk("t1_latency", 128'(cyc + 1), 128'd12);
    chk("t1_done", 128'(kx.done), 128'd1);
    chk("t1_valid_low", 128'(kx.rk_valid), 128'd0);
    chk("t1_busy_low", 128'(kx.busy), 128'd0);
    step();
    chk("t1_done_pulse", 128'(kx.done), 128'd0);

    // T2: all-zero key
    pulse_start(128'd0);
    kx.rk_ready = 1'b0;
    chk("t2_idx0", kx.rk_out, 128'd0);
    step();
    chk("t2_hold", kx.rk_out, 128'd0);
    kx.rk_ready = 1'b1;
    step();
    chk("t2_idx1_n", 128'(kx.rk_idx), 128'd1);
    chk("t2_idx1", kx.rk_out, Z1);
    cyc = 0;
    while (!kx.done && cyc < 50) begin
      step();
      cyc++;
    end
    chk("t2_done", 128'(kx.done), 128'd1);
    step();

    // T3: random back-pressure
    pulse_start(K1);
    drain(1'b1, -1, hs, dn, cyc);
    chk("t3_one_done", 128'(dn), 128'd1);
    step();
    chk("t3_idle", 128'(kx.busy), 128'd0);

    // T4: start at idx5 with a different key is ignored
    pulse_start(K1);
    drain(1'b0, 5, hs, dn, cyc);
    chk("t4_one_done", 128'(dn), 128'd1);
    step();

    // T5: reset at idx4 aborts without done, then a fresh run is complete
    pulse_start(K1);
    kx.rk_ready = 1'b1;
    repeat (4) step();
    chk("t5_at_idx4", 128'(kx.rk_idx), 128'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", 128'(kx.rk_valid), 128'd0);
    chk("t5_busy", 128'(kx.busy), 128'd0);
    chk("t5_idx", 128'(kx.rk_idx), 128'd0);
    chk("t5_done", 128'(kx.done), 128'd0);
    step();
    chk("t5_no_done", 128'(kx.done), 128'd0);
    pulse_start(K1);
    drain(1'b0, -1, hs, dn, cyc);
    chk("t5_rerun_done", 128'(dn), 128'd1);
    step();

    // T6: start held across the final handshake
    pulse_start(K1);
    kx.start    = 1'b1;
    kx.key_in   = ALT;
    kx.rk_ready = 1'b1;
    repeat (10) step();
    chk("t6_idx10", 128'(kx.rk_idx), 128'd10);
    chk("t6_key10", kx.rk_out, t1[10]);
    step();
    chk("t6_done", 128'(kx.done), 128'd1);
    chk("t6_valid_low", 128'(kx.rk_valid), 128'd0);
    kx.key_in = 128'd0;
    step();
    kx.start  = 1'b0;
    kx.key_in = ALT;
    chk("t6_restart_valid", 128'(kx.rk_valid), 128'd1);
    chk("t6_restart_idx", 128'(kx.rk_idx), 128'd0);
    chk("t6_restart_key", kx.rk_out, 128'd0);
    chk("t6_done_clear", 128'(kx.done), 128'd0);
    step();
    chk("t6_idx1", kx.rk_out, Z1);
    cyc = 0;
    while (!kx.done && cyc < 50) begin
      step();
      cyc++;
    end
    chk("t6_final_done", 128'(kx.done), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
